adc_virtual_producer: RTL and testbench

Paced writer that fills the virtual-ADC circular buffer in BRAM with samples from a valid/ready source at a programmable sample rate. It sits directly upstream of `adc_access_counter`: it drives the BRAM write port, publishes the producer word index and reads back the consumer word index to detect overrun. It also flags late samples.

---
 rtl/adc_femu_pkg.sv | 14 +
 rtl/adc_rate_timer.sv | 28 ++
 rtl/adc_virtual_producer.sv | 127 ++++++++++++
 tb/tb_adc_virtual_producer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_femu_pkg.sv
// Shared definitions for the virtual-ADC front-end emulation blocks.
package adc_femu_pkg;

  localparam int         ADC_BITS_DEFAULT = 10;
  localparam logic [3:0] BRAM_WE_WORD     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_FETCH,
    ST_WRITE
  } prod_state_e;

endpackage

// File: rtl/adc_rate_timer.sv
// Programmable rate timer: counts 0..period and pulses tick on the terminal count.
module adc_rate_timer
  import adc_femu_pkg::*;
#(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DIV_BITS-1:0] period,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt_p0;

  assign tick = run && (cnt_p0 == period);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 == period) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/adc_virtual_producer.sv
// Paced producer filling the virtual-ADC circular buffer in BRAM from a valid/ready source.
module adc_virtual_producer
  import adc_femu_pkg::*;
#(
  parameter int ADC_BITS       = ADC_BITS_DEFAULT,
  parameter int BRAM_ADDR_BITS = 32,
  parameter int DIV_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DIV_BITS-1:0]       sample_period,
  input  logic [31:0]               s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [BRAM_ADDR_BITS-1:0] bram_addr,
  output logic [31:0]               bram_din,
  output logic                      bram_en,
  output logic [3:0]                bram_we,
  output logic [ADC_BITS-1:0]       ADC_buffer_prod_out,
  input  logic [ADC_BITS-1:0]       ADC_buffer_cons_in,
  input  logic                      flags_clr,
  output logic                      overrun,
  output logic                      underrun,
  output logic [31:0]               sample_cnt
);

  prod_state_e         state_p0;
  prod_state_e         state_nxt;
  logic                timer_run;
  logic                tick;
  logic                accept;
  logic                full;
  logic                write_go;
  logic                drop;
  logic                late;
  logic [ADC_BITS-1:0] prod_p0;
  logic [ADC_BITS-1:0] prod_inc;
  logic [31:0]         sample_p0;
  logic [31:0]         sample_cnt_p0;
  logic                overrun_p0;
  logic                underrun_p0;

  assign timer_run = enable && (state_p0 != ST_IDLE);

  adc_rate_timer #(
    .DIV_BITS(DIV_BITS)
  ) u_rate_timer (
    .clk   (clk),
    .reset (reset),
    .run   (timer_run),
    .period(sample_period),
    .tick  (tick)
  );

  // Full uses modular index arithmetic; the consumer index only matters in WRITE.
  assign prod_inc = prod_p0 + ADC_BITS'(1);
  assign full     = (prod_inc == ADC_buffer_cons_in);
  assign accept   = (state_p0 == ST_FETCH) && enable && s_valid;
  assign write_go = (state_p0 == ST_WRITE) && !full;
  assign drop     = (state_p0 == ST_WRITE) && full;
  assign late     = tick && ((state_p0 == ST_FETCH) || (state_p0 == ST_WRITE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable)   state_nxt = ST_IDLE;
        else if (tick) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!enable)     state_nxt = ST_IDLE;
        else if (accept) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = enable ? ST_WAIT_TICK : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_p0 == ST_FETCH) && enable;
    bram_en = write_go;
    bram_we = write_go ? BRAM_WE_WORD : 4'b0000;
  end

  // Stage p0: captured sample, write pointer, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_p0     <= '0;
      prod_p0       <= '0;
      sample_cnt_p0 <= '0;
      overrun_p0    <= 1'b0;
      underrun_p0   <= 1'b0;
    end else begin
      if (accept) sample_p0 <= s_data;
      if (write_go) begin
        prod_p0       <= prod_inc;
        sample_cnt_p0 <= sample_cnt_p0 + 32'd1;
      end
      if (drop)           overrun_p0 <= 1'b1;
      else if (flags_clr) overrun_p0 <= 1'b0;
      if (late)           underrun_p0 <= 1'b1;
      else if (flags_clr) underrun_p0 <= 1'b0;
    end
  end

  assign bram_addr           = BRAM_ADDR_BITS'({prod_p0, 2'b00});
  assign bram_din            = sample_p0;
  assign ADC_buffer_prod_out = prod_p0;
  assign overrun             = overrun_p0;
  assign underrun            = underrun_p0;
  assign sample_cnt          = sample_cnt_p0;

endmodule

// File: tb/tb_adc_virtual_producer.sv
// Self-checking bench for adc_virtual_producer: behavioural buffer model plus directed and random traffic.
module tb_adc_virtual_producer;

  localparam int AB = 4;
  localparam int N  = 1 << AB;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] sample_period;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [AB-1:0] prod_out;
  logic [AB-1:0] cons;
  logic        flags_clr;
  logic        overrun;
  logic        underrun;
  logic [31:0] sample_cnt;

  adc_virtual_producer #(
    .ADC_BITS(AB),
    .BRAM_ADDR_BITS(32),
    .DIV_BITS(16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .sample_period      (sample_period),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .bram_addr          (bram_addr),
    .bram_din           (bram_din),
    .bram_en            (bram_en),
    .bram_we            (bram_we),
    .ADC_buffer_prod_out(prod_out),
    .ADC_buffer_cons_in (cons),
    .flags_clr          (flags_clr),
    .overrun            (overrun),
    .underrun           (underrun),
    .sample_cnt         (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: the source/buffer relationship in terms of "sample owed" and "sample held".
  bit        m_on;
  bit        m_hungry;
  bit        m_hold;
  bit [31:0] m_data;
  int        m_prod;
  bit [31:0] m_cnt;
  bit        m_ovr;
  bit        m_und;
  int        m_phase;
  bit        m_full;
  bit        m_tick;
  int        cyc = 0;

  assign m_full = (((m_prod + 1) % N) == int'(cons));
  assign m_tick = m_on && enable && (m_phase == int'(sample_period));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_on <= 0; m_hungry <= 0; m_hold <= 0; m_data <= 0;
      m_prod <= 0; m_cnt <= 0; m_ovr <= 0; m_und <= 0; m_phase <= 0;
    end else begin
      if (m_hold) begin
        if (!m_full) begin
          m_prod <= (m_prod + 1) % N;
          m_cnt  <= m_cnt + 1;
        end
        m_hold <= 0;
        m_on   <= enable;
      end else if (m_hungry) begin
        if (!enable) begin
          m_hungry <= 0;
          m_on     <= 0;
        end else if (s_valid) begin
          m_hungry <= 0;
          m_hold   <= 1;
          m_data   <= s_data;
        end
      end else if (m_on) begin
        if (!enable)     m_on <= 0;
        else if (m_tick) m_hungry <= 1;
      end else if (enable) begin
        m_on <= 1;
      end
      m_ovr   <= (m_hold && m_full) ? 1'b1 : (flags_clr ? 1'b0 : m_ovr);
      m_und   <= (m_tick && (m_hungry || m_hold)) ? 1'b1 : (flags_clr ? 1'b0 : m_und);
      m_phase <= (m_on && enable && m_phase != int'(sample_period)) ? m_phase + 1 : 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    int          c;
  } wr_t;

  wr_t wlog[$];
  bit  hs_seen;

  always @(negedge clk) begin
    bit wr_exp;
    wr_exp = m_hold && !m_full;
    chk("s_ready", s_ready, m_hungry && enable);
    chk("bram_en", bram_en, wr_exp);
    chk("bram_we", bram_we, wr_exp ? 4'hF : 4'h0);
    if (wr_exp) begin
      chk("bram_addr", bram_addr, m_prod * 4);
      chk("bram_din", bram_din, m_data);
    end
    chk("prod_out", prod_out, m_prod);
    chk("sample_cnt", sample_cnt, m_cnt);
    chk("overrun", overrun, m_ovr);
    chk("underrun", underrun, m_und);
    if (bram_en === 1'b1) wlog.push_back('{addr: bram_addr, din: bram_din, c: cyc});
    hs_seen = s_ready && s_valid;
  end

  bit auto_data = 1;
  int dn = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (auto_data && hs_seen) begin
        dn++;
        s_data = 32'h100 + dn;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1;
    step(2);
    reset = 0;
    dn = 0;
    s_data = 32'h100;
    wlog.delete();
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k = 0;
    while (wlog.size() < target && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_writes", wlog.size(), target);
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!s_ready && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_s_ready", s_ready, 1);
  endtask

  initial begin
    int k;
    reset = 1; enable = 0; sample_period = 16'd3; s_data = 32'h100;
    s_valid = 0; cons = '0; flags_clr = 0;

    // Post-reset idle
    step(2);
    reset = 0;
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_din", bram_din, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_prod", prod_out, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    wlog.delete();
    step(20);
    chk("idle_no_writes", wlog.size(), 0);

    // Streaming then full buffer
    sample_period = 16'd3; s_valid = 1; enable = 1;
    wait_writes(3, 40);
    chk("stream_addr0", wlog[0].addr, 32'h0);
    chk("stream_addr1", wlog[1].addr, 32'h4);
    chk("stream_addr2", wlog[2].addr, 32'h8);
    chk("stream_din0", wlog[0].din, 32'h100);
    chk("stream_din2", wlog[2].din, 32'h102);
    chk("stream_gap1", wlog[1].c - wlog[0].c, 4);
    chk("stream_gap2", wlog[2].c - wlog[1].c, 4);
    chk("stream_prod", prod_out, 3);
    chk("stream_cnt", sample_cnt, 3);
    wait_writes(15, 200);
    chk("full_prod15", prod_out, 15);
    chk("full_cnt15", sample_cnt, 15);
    k = 0;
    while (!overrun && k < 20) begin step(1); k++; end
    chk("full_overrun", overrun, 1);
    chk("full_dropped", wlog.size(), 15);
    chk("full_prod_held", prod_out, 15);
    cons = 4'd5;
    wait_writes(16, 20);
    chk("wrap_addr", wlog[15].addr, 32'h3C);
    chk("wrap_din", wlog[15].din, 32'h110);
    chk("wrap_prod", prod_out, 0);
    chk("wrap_cnt", sample_cnt, 16);

    // Underrun
    enable = 0; s_valid = 0; cons = '0;
    do_reset();
    sample_period = 16'd2; enable = 1;
    wait_ready(20);
    step(6);
    chk("underrun_set", underrun, 1);
    s_valid = 1;
    step(1);
    s_valid = 0;
    step(10);
    chk("underrun_one_write", wlog.size(), 1);

    // Clear priority
    enable = 0;
    do_reset();
    cons = 4'd1; sample_period = 16'd2; enable = 1;
    wait_ready(20);
    s_valid = 1;
    step(1);
    s_valid = 0; flags_clr = 1;
    step(1);
    flags_clr = 0;
    chk("clr_vs_set", overrun, 1);
    step(2);
    flags_clr = 1;
    step(1);
    flags_clr = 0;
    chk("clr_alone", overrun, 0);
    chk("clr_no_write", wlog.size(), 0);

    // Disable mid-flow, retention, reset during WRITE
    enable = 0; cons = '0;
    do_reset();
    sample_period = 16'd3; s_valid = 1; enable = 1;
    wait_writes(2, 40);
    s_valid = 0;
    wait_ready(20);
    enable = 0;
    step(1);
    chk("dis_s_ready", s_ready, 0);
    step(5);
    chk("dis_no_write", wlog.size(), 2);
    chk("dis_prod_kept", prod_out, 2);
    enable = 1; s_valid = 1;
    wait_writes(3, 30);
    chk("reen_addr", wlog[2].addr, 32'h8);
    chk("reen_prod", prod_out, 3);
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (bram_en) break;
      k++;
    end
    chk("rst_wr_seen", bram_en, 1);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("rst_wr_en", bram_en, 0);
    chk("rst_wr_prod", prod_out, 0);
    chk("rst_wr_cnt", sample_cnt, 0);

    // Random traffic against the model
    auto_data = 0;
    for (int seg = 0; seg < 25; seg++) begin
      enable = 0; reset = 0;
      step(2);
      sample_period = 16'($urandom_range(0, 4));
      enable = 1;
      for (int i = 0; i < 100; i++) begin
        s_valid   = ($urandom_range(0, 3) != 0);
        s_data    = $urandom;
        if ($urandom_range(0, 7) == 0) cons = AB'($urandom_range(0, N - 1));
        flags_clr = ($urandom_range(0, 15) == 0);
        reset     = ($urandom_range(0, 199) == 0);
        enable    = ($urandom_range(0, 19) != 0);
        step(1);
      end
    end
    reset = 0; flags_clr = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
